// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the ALU control decoder
// and the execute-stage ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR) ||
               (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: add/sub/and/or with zero, signed-overflow and
// illegal-op flags. Unsupported codes yield a zero result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Overflow: operand signs agree (b inverted for sub) but the result sign differs.
    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = !is_legal_op(op);
        case (op)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage pipelined execute ALU with valid/ready handshakes on both sides,
// synchronous flush and a saturating count of handed-off results.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_ovf;
    logic             s2_illegal;
    logic [TAG_W-1:0] s2_tag;

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_ovf;
    logic             core_illegal;

    logic s1_adv;
    logic s2_adv;
    logic in_xfer;
    logic out_xfer;

    // in_ready never looks at in_valid so the upstream stage can rely on it.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv && rst_n && !flush;
        in_xfer  = in_valid && in_ready;
        out_xfer = s2_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_op  <= in_op;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op      (s1_op),
        .a       (s1_a),
        .b       (s1_b),
        .result  (core_result),
        .zero    (core_zero),
        .ovf     (core_ovf),
        .illegal (core_illegal)
    );

    // A flush squashes S2 even if it is being handed off this same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result  <= core_result;
                s2_zero    <= core_zero;
                s2_ovf     <= core_ovf;
                s2_illegal <= core_illegal;
                s2_tag     <= s1_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_xfer && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_zero    = s2_zero;
    assign out_ovf     = s2_ovf;
    assign out_illegal = s2_illegal;
    assign out_tag     = s2_tag;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued on input
// acceptance and compared when the unit hands them off.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int CNT_W = 16;
    localparam longint MAXS = 2147483647;
    localparam longint MINS = -MAXS - 1;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } stim_t;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             illegal;
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_ovf;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] op_count;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    model_count = 0;
    logic  strict_lat = 1'b0;
    logic  last_in_ready = 1'b0;

    alu_exec_unit #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_ovf     (out_ovf),
        .out_illegal (out_illegal),
        .out_tag     (out_tag),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", name, obs, expv, cyc);
        end
    endtask

    // Reference computed with 64-bit signed arithmetic and range checks.
    function automatic exp_t modelAlu(input stim_t s, input int c);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(s.a));
        sb = longint'($signed(s.b));
        e.result  = '0;
        e.ovf     = 1'b0;
        e.illegal = 1'b0;
        e.tag     = s.tag;
        e.acc_cyc = c;
        case (s.op)
            4'b0010: begin
                r = sa + sb;
                e.result = r[WIDTH-1:0];
                e.ovf = (r > MAXS) || (r < MINS);
            end
            4'b0110: begin
                r = sa - sb;
                e.result = r[WIDTH-1:0];
                e.ovf = (r > MAXS) || (r < MINS);
            end
            4'b0000: e.result = s.a & s.b;
            4'b0001: e.result = s.a | s.b;
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    function automatic stim_t mkStim(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        stim_t s;
        s.op = op;
        s.a = a;
        s.b = b;
        s.tag = tag;
        return s;
    endfunction

    // Scoreboard step: compare any hand-off, queue any acceptance, then advance one edge.
    task automatic stepCycle();
        exp_t e;
        logic acc;
        @(negedge clk);
        cyc++;
        last_in_ready = in_ready;
        acc = in_valid && in_ready;
        if (rst_n && out_valid && out_ready) begin
            if (model_count < 65535) model_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out", 64'(out_tag), 64'hdead);
            end else begin
                e = exp_q.pop_front();
                checkOutput("result", 64'(out_result), 64'(e.result));
                checkOutput("zero", 64'(out_zero), 64'(e.zero));
                checkOutput("ovf", 64'(out_ovf), 64'(e.ovf));
                checkOutput("illegal", 64'(out_illegal), 64'(e.illegal));
                checkOutput("tag", 64'(out_tag), 64'(e.tag));
                if (strict_lat) checkOutput("latency", 64'(cyc - e.acc_cyc), 64'd2);
            end
        end
        if (!rst_n || flush) exp_q.delete();
        else if (acc) exp_q.push_back(modelAlu(mkStim(in_op, in_a, in_b, in_tag), cyc));
        if (!rst_n) model_count = 0;
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int ncycles);
        for (int i = 0; i < ncycles; i++) begin
            in_valid = (stim_q.size() > 0);
            if (stim_q.size() > 0) begin
                in_op  = stim_q[0].op;
                in_a   = stim_q[0].a;
                in_b   = stim_q[0].b;
                in_tag = stim_q[0].tag;
            end
            stepCycle();
            if (in_valid && last_in_ready) void'(stim_q.pop_front());
        end
        in_valid = 1'b0;
    endtask

    task automatic drainAll(input string name);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while ((exp_q.size() > 0 || stim_q.size() > 0) && guard < 60) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput({name, "_drained"}, 64'(exp_q.size() + stim_q.size()), 64'd0);
        checkOutput({name, "_op_count"}, 64'(op_count), 64'(model_count));
    endtask

    initial begin
        logic [WIDTH-1:0] held_result;
        logic [TAG_W-1:0] held_tag;
        int               count0;
        int               guard;
        logic [3:0]       rop;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        @(posedge clk);
        #2;
        stepCycle();
        stepCycle();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_result", 64'(out_result), 64'd0);
        checkOutput("rst_out_flags", 64'({out_zero, out_ovf, out_illegal}), 64'd0);
        checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
        checkOutput("rst_op_count", 64'(op_count), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Back-to-back stream at full throughput.
        strict_lat = 1'b1;
        stim_q.push_back(mkStim(4'b0010, 32'h5, 32'h7, 5'd1));
        stim_q.push_back(mkStim(4'b0110, 32'h3, 32'h3, 5'd2));
        stim_q.push_back(mkStim(4'b0000, 32'hF0, 32'h3C, 5'd3));
        stim_q.push_back(mkStim(4'b0001, 32'hF0, 32'h0F, 5'd4));
        applyStimulus(4);
        checkOutput("stream_all_accepted", 64'(stim_q.size()), 64'd0);
        drainAll("stream");
        checkOutput("stream_count4", 64'(op_count), 64'd4);

        // Overflow and illegal-op boundaries.
        stim_q.push_back(mkStim(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd5));
        stim_q.push_back(mkStim(4'b0110, 32'h80000000, 32'h1, 5'd6));
        stim_q.push_back(mkStim(4'b0110, 32'h5, 32'h7, 5'd7));
        stim_q.push_back(mkStim(4'b0111, 32'h9, 32'h9, 5'd19));
        applyStimulus(4);
        drainAll("ovf");
        strict_lat = 1'b0;

        // Backpressure: two accepts fill the pipe, then everything holds.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            stim_q.push_back(mkStim(4'b0010, 32'(100 + i), 32'(i), 5'(20 + i)));
        applyStimulus(2);
        held_result = out_result;
        held_tag = out_tag;
        applyStimulus(3);
        checkOutput("bp_accepts", 64'(5 - stim_q.size()), 64'd2);
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_hold_result", 64'(out_result), 64'(held_result));
        checkOutput("bp_hold_tag", 64'(out_tag), 64'(held_tag));
        out_ready = 1'b1;
        count0 = model_count;
        applyStimulus(3);
        checkOutput("bp_release3", 64'(model_count - count0), 64'd3);
        drainAll("bp");

        // Flush with both stages full and an op offered.
        stim_q.push_back(mkStim(4'b0001, 32'h1, 32'h2, 5'd8));
        stim_q.push_back(mkStim(4'b0010, 32'h3, 32'h4, 5'd9));
        applyStimulus(2);
        checkOutput("flush_pre_valid", 64'(out_valid), 64'd1);
        count0 = model_count;
        flush = 1'b1;
        stim_q.push_back(mkStim(4'b0000, 32'hFF, 32'hFF, 5'd10));
        applyStimulus(1);
        flush = 1'b0;
        checkOutput("flush_in_ready", 64'(last_in_ready), 64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_counted", 64'(op_count), 64'(count0 + 1));
        stim_q.delete();
        applyStimulus(2);
        checkOutput("flush_no_stale", 64'(out_valid), 64'd0);
        drainAll("flush");

        // Reset mid-stream with two ops in flight.
        out_ready = 1'b0;
        stim_q.push_back(mkStim(4'b0010, 32'h11, 32'h22, 5'd11));
        stim_q.push_back(mkStim(4'b0110, 32'h40, 32'h1, 5'd12));
        applyStimulus(2);
        checkOutput("mid_rst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
        stepCycle();
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_result", 64'(out_result), 64'd0);
        checkOutput("mid_rst_flags", 64'({out_zero, out_ovf, out_illegal}), 64'd0);
        checkOutput("mid_rst_tag", 64'(out_tag), 64'd0);
        checkOutput("mid_rst_op_count", 64'(op_count), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("mid_rst_release_ready", 64'(in_ready), 64'd1);
        applyStimulus(3);
        checkOutput("mid_rst_no_stale", 64'(out_valid), 64'd0);

        // Random stream with random backpressure.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0: rop = 4'b0010;
                1: rop = 4'b0110;
                2: rop = 4'b0000;
                3: rop = 4'b0001;
                default: rop = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'b0011;
            endcase
            stim_q.push_back(mkStim(rop, $urandom, $urandom, 5'($urandom_range(0, 31))));
        end
        guard = 0;
        while (stim_q.size() > 0 && guard < 300) begin
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(1);
            guard++;
        end
        checkOutput("rand_feed_done", 64'(stim_q.size()), 64'd0);
        drainAll("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
